// File: rtl/montgomery_encoder.sv
// montgomery_encoder
//
// Converts a standard residue x (0 <= x < m) into Montgomery form
// x * 2^k mod m. It uses a bit-serial double-and-conditional-subtract loop,
// one step per clock. One operand is in flight at a time, and a
// start/busy/valid handshake controls the transfer.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     asynchronous active-high reset
//   start_i   request; honoured only in IDLE or DONE
//   x_i       standard-form operand (must be < m_i)
//   m_i       odd, nonzero modulus
//   m_bl_i    k, the exponent of R = 2^k (0..WIDTH)
//   result_o  x * 2^k mod m; held until the next completion
//   valid_o   one-cycle completion pulse
//   err_o     qualifies valid_o: input rejected, result_o = 0
//   busy_o    conversion loop running
module montgomery_encoder #(
   parameter int WIDTH = 64,
   parameter int BLW   = 7
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] m_i,
   input  logic [BLW-1:0]   m_bl_i,
   output logic [WIDTH-1:0] result_o,
   output logic             valid_o,
   output logic             err_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   localparam logic [BLW-1:0] WidthBl = BLW'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [BLW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] dbl;
   logic             dbl_ge_m;
   logic [WIDTH-1:0] acc_step;
   logic             reject;

   // The doubled accumulator is WIDTH+1 bits wide: {acc, 0}.
   // Its top bit is acc[WIDTH-1]. When that bit is set, the value is
   // already >= 2^WIDTH > m. Because acc < m, the difference always fits
   // in WIDTH bits. So the subtraction can be done modulo 2^WIDTH on the
   // low bits alone.
   assign dbl      = {acc_q[WIDTH-2:0], 1'b0};
   assign dbl_ge_m = acc_q[WIDTH-1] || (dbl >= m_q);
   assign acc_step = dbl_ge_m ? (dbl - m_q) : dbl;

   assign reject = (m_i == '0) || (x_i >= m_i) || (m_bl_i > WidthBl);

   // Next-state logic. The result and error registers change only when an
   // operation completes. The operands are latched only at the accepting
   // edge, so later input changes cannot disturb a running conversion.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      err_d    = err_q;

      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               if (reject) begin
                  result_d = '0;
                  err_d    = 1'b1;
                  state_d  = DONE;
               end else if (m_bl_i == '0) begin
                  // R = 1, so the operand is already in Montgomery form.
                  result_d = x_i;
                  err_d    = 1'b0;
                  state_d  = DONE;
               end else begin
                  acc_d   = x_i;
                  m_d     = m_i;
                  cnt_d   = m_bl_i;
                  state_d = CONV;
               end
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end

         CONV: begin
            acc_d = acc_step;
            cnt_d = cnt_q - BLW'(1);
            // The last doubling step writes the result directly, so valid
            // appears k cycles after acceptance.
            if (cnt_q == BLW'(1)) begin
               result_d = acc_step;
               err_d    = 1'b0;
               state_d  = DONE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. Reset aborts any conversion at once,
   // and no completion pulse is issued for the aborted operand.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         m_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign result_o = result_q;
   assign err_o    = err_q;
   assign valid_o  = (state_q == DONE);
   assign busy_o   = (state_q == CONV);

endmodule

// File: tb/tb_montgomery_encoder.sv
// tb_montgomery_encoder
//
// Self-checking bench for montgomery_encoder. Table-driven single
// operations are followed by hand-written sequences: a back-to-back sweep,
// input disturbance during conversion, and reset in the middle of a
// conversion. Expected results are queued when stimulus is driven and
// compared when valid_o appears.
module tb_montgomery_encoder;

   localparam int WIDTH = 64;
   localparam int BLW   = 7;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] m;
   logic [BLW-1:0]   bl;
   logic [WIDTH-1:0] result;
   logic             valid;
   logic             err;
   logic             busy;

   typedef struct {
      logic [63:0] result;
      logic        err;
      int          lat;
   } exp_t;

   typedef struct {
      logic [63:0] x;
      logic [63:0] m;
      logic [6:0]  bl;
      logic [63:0] expResult;
      logic        expErr;
   } vec_t;

   exp_t sbQ[$];
   vec_t vecs[9];

   int checks = 0;
   int errors = 0;

   montgomery_encoder #(
      .WIDTH(WIDTH),
      .BLW  (BLW)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .x_i     (x),
      .m_i     (m),
      .m_bl_i  (bl),
      .result_o(result),
      .valid_o (valid),
      .err_o   (err),
      .busy_o  (busy)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Guards against a stuck simulation independent of the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one request at a negedge and queues its expected outcome. The
   // task returns at the negedge that follows the accepting edge.
   task automatic applyStimulus(input logic [63:0] xv, input logic [63:0] mv,
                                input logic [6:0] blv, input logic [63:0] expR,
                                input logic expE, input bit holdStart);
      exp_t e;
      x     = xv;
      m     = mv;
      bl    = blv;
      start = 1'b1;
      e.result = expR;
      e.err    = expE;
      e.lat    = (expE || blv == 7'd0) ? 0 : int'(blv);
      sbQ.push_back(e);
      @(negedge clk);
      if (!holdStart) start = 1'b0;
   endtask

   // Waits (bounded) for valid_o while counting cycles since acceptance
   // and busy cycles, then compares the result against the queued entry.
   task automatic checkOutput(input string tag, input int startLat, input bit expectIdleAfter);
      exp_t e;
      int   lat;
      int   busyCnt;
      lat     = startLat;
      busyCnt = 0;
      while (!valid && lat < 200) begin
         if (busy) busyCnt++;
         @(negedge clk);
         lat++;
      end
      if (!valid) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s.timeout: got no valid_o, required valid_o within 200 cycles", tag);
         if (sbQ.size() != 0) void'(sbQ.pop_front());
         return;
      end
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s.unexpectedValid: got valid_o=1, required no pending result", tag);
         return;
      end
      e = sbQ.pop_front();
      checkVal({tag, ".result"}, result, e.result);
      checkVal({tag, ".err"}, 64'(err), 64'(e.err));
      checkVal({tag, ".latency"}, 64'(lat), 64'(e.lat));
      checkVal({tag, ".busyCycles"}, 64'(busyCnt), 64'(e.lat - startLat));
      if (expectIdleAfter) begin
         @(negedge clk);
         checkVal({tag, ".validPulse"}, 64'(valid), 64'd0);
         checkVal({tag, ".resultHold"}, result, e.result);
         checkVal({tag, ".busyIdle"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      int validSeen;

      vecs[0] = '{64'h1,   64'hD01,    7'd12, 64'h2FF,  1'b0};
      vecs[1] = '{64'h123, 64'hD01,    7'd0,  64'h123,  1'b0};
      vecs[2] = '{64'h1,   64'h7FE001, 7'd23, 64'h1FFF, 1'b0};
      vecs[3] = '{64'hD01, 64'hD01,    7'd12, 64'h0,    1'b1};
      vecs[4] = '{64'h5,   64'h0,      7'd12, 64'h0,    1'b1};
      vecs[5] = '{64'h1,   64'hD01,    7'd65, 64'h0,    1'b1};
      vecs[6] = '{64'hABC, 64'hD01,    7'd12, 64'h1CB,  1'b0};
      vecs[7] = '{64'h1,   64'hFFFF_FFFF_FFFF_FFC5, 7'd64, 64'h3B, 1'b0};
      vecs[8] = '{64'h2,   64'hFFFF_FFFF_FFFF_FFC5, 7'd64, 64'h76, 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      x     = '0;
      m     = '0;
      bl    = '0;
      repeat (3) @(negedge clk);
      checkVal("reset.result", result, 64'h0);
      checkVal("reset.valid", 64'(valid), 64'd0);
      checkVal("reset.err", 64'(err), 64'd0);
      checkVal("reset.busy", 64'(busy), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] table-driven single operations");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].x, vecs[i].m, vecs[i].bl, vecs[i].expResult, vecs[i].expErr, 1'b0);
         checkOutput($sformatf("vec%0d", i), 0, 1'b1);
      end

      // start_i held high: the next operand is accepted from DONE, so
      // results arrive every k+1 cycles.
      $display("[TB] back-to-back sweep");
      applyStimulus(64'h000, 64'hD01, 7'd12, 64'h000, 1'b0, 1'b1);
      checkOutput("sweep0", 0, 1'b0);
      applyStimulus(64'h002, 64'hD01, 7'd12, 64'h5FE, 1'b0, 1'b1);
      checkOutput("sweep1", 0, 1'b0);
      applyStimulus(64'hD00, 64'hD01, 7'd12, 64'hA02, 1'b0, 1'b0);
      checkOutput("sweep2", 0, 1'b1);

      // Inputs and start_i wiggle while the loop runs.
      $display("[TB] disturbance during conversion");
      applyStimulus(64'h1, 64'hD01, 7'd12, 64'h2FF, 1'b0, 1'b0);
      start = 1'b1;
      x     = 64'(($urandom % 3328) + 1);
      m     = 64'h0;
      @(negedge clk);
      start = 1'b0;
      x     = 64'h5A5;
      bl    = 7'd3;
      @(negedge clk);
      start = 1'b1;
      x     = 64'hD01;
      @(negedge clk);
      start = 1'b0;
      x     = 64'h0;
      checkOutput("disturb", 3, 1'b1);

      // Reset while CONV runs: outputs clear at once and no valid pulse.
      $display("[TB] reset during conversion");
      x     = 64'h7;
      m     = 64'hD01;
      bl    = 7'd12;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checkVal("midReset.busyBefore", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      checkVal("midReset.result", result, 64'h0);
      checkVal("midReset.valid", 64'(valid), 64'd0);
      checkVal("midReset.err", 64'(err), 64'd0);
      checkVal("midReset.busy", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      validSeen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (valid) validSeen++;
      end
      checkVal("midReset.noValid", 64'(validSeen), 64'd0);

      $display("[TB] recovery after reset");
      applyStimulus(64'h1, 64'hD01, 7'd12, 64'h2FF, 1'b0, 1'b0);
      checkOutput("recover", 0, 1'b1);

      checkVal("scoreboard.empty", 64'(sbQ.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/montgomery_encoder.md
# montgomery_encoder

Iterative converter that maps a standard residue x (0 ≤ x < m) into Montgomery form x·R mod m, with R = 2^k and k = m_bl_i. It sits in front of `montgomery_pipelined`. That block consumes Montgomery-form operands and reduces them back to standard form, so this block is the forward direction of the same data path. Conversion is a bit-serial double-and-conditional-subtract loop with a start/busy/valid handshake, one operand in flight at a time.

## Interface
- WIDTH, 64, operand and modulus width in bits
- BLW, 7, width of the bit-length field; must hold values 0..WIDTH
- clk_i  in  1  clock, rising edge active
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request; sampled only in IDLE or DONE
- x_i  in  WIDTH  standard-form operand; must satisfy x_i < m_i
- m_i  in  WIDTH  modulus, odd, nonzero
- m_bl_i  in  BLW  k = exponent of R (ceil(log2 m), e.g. 12 for 0xD01)
- result_o  out  WIDTH  x·2^k mod m; holds until the next accepted start
- valid_o  out  1  one-cycle pulse, result_o valid
- err_o  out  1  qualifies valid_o: input rejected, result_o = 0
- busy_o  out  1  conversion loop running

## Operation
- States: IDLE, CONV, DONE.
- **Input capture.** x_i, m_i and m_bl_i are captured only at the edge that accepts start_i. Later input changes have no effect on an operation in flight.
- **Rejection.** An input is rejected if m_i == 0, x_i ≥ m_i, or m_bl_i > WIDTH.
  - A rejected input goes straight to DONE with err_o = 1 and result_o = 0.
  - A rejected input never enters CONV.
- **Accept with k = 0.** The block goes straight to DONE with result_o = x_i and err_o = 0 (R = 1).
- **Accept with k > 0.** The block sets acc ← x_i and cnt ← k, then moves to CONV.
- **CONV iteration.** Each edge does:
  - t = {acc, 1'b0} (WIDTH+1 bits);
  - acc ← (t ≥ m) ? t − m : t;
  - cnt ← cnt − 1.
  - Invariant: acc < m always, so the WIDTH+1-bit t never overflows.
- **CONV exit.** When cnt reaches 0, result_o ← the final acc, err_o ← 0, and the state moves to DONE.
- **DONE.** valid_o = 1 for exactly this one cycle.
  - If start_i = 1 in DONE, the new operand is accepted as in IDLE (back-to-back).
  - Otherwise the state returns to IDLE.
- **start_i during CONV** is ignored. There is no queuing.
- **busy_o** = 1 only in CONV.
- **result_o and err_o** are registered and hold their value until overwritten by the next accepted start's completion.

## Timing
- **Reset values:** state = IDLE, result_o = 0, valid_o = 0, err_o = 0, busy_o = 0, acc = 0, cnt = 0.
- **Reset mid-CONV:** the block returns to IDLE immediately (asynchronously). No valid_o pulse is issued for the aborted operand.
- **Latency for k > 0.** Let start be accepted at edge N.
  - busy_o is high from edge N to edge N+k.
  - The k doubling steps happen at edges N+1 … N+k.
  - valid_o and result_o are visible after edge N+k, i.e. k cycles after acceptance.
- **Latency for k = 0 or a rejected input:** valid_o is visible after edge N (1 cycle).
- **Throughput:** k+1 cycles per operand when start_i is held high continuously.
- **Reset priority:** rst_i overrides start_i.

## Test plan
- **Kyber, x = 1.** m = 0xD01, k = 12, x = 0x001, start pulsed → busy_o high for 12 cycles; valid_o pulse 12 cycles after acceptance; result_o = 0x2FF; err_o = 0.
- **Kyber sweep.** m = 0xD01, k = 12, start held high → back-to-back results every 13 cycles:
  - x = 0x000 → 0x000
  - x = 0x002 → 0x5FE
  - x = 0xD00 → 0xA02
- **Dilithium, x = 1.** m = 0x7FE001, k = 23, x = 0x1 → result_o = 0x1FFF after 23 cycles.
- **Errors.** Each case gives a valid_o pulse 1 cycle after acceptance with err_o = 1 and result_o = 0:
  - x = 0xD01 with m = 0xD01;
  - m = 0;
  - m_bl = 65.
- **k = 0.** m = 0xD01, x = 0x123 → result_o = 0x123 after 1 cycle.
- **Disturbance.**
  - start_i and x_i toggled during CONV → no effect; the original result is still 0x2FF.
  - rst_i asserted at cycle 5 of CONV → outputs go to 0 asynchronously; no valid_o pulse.
  - After reset is released, a new start with x = 1 returns 0x2FF.
